// File: rtl/scr1_dmem_router_pkg.sv
//==============================================================================
// Module : scr1_dmem_router_pkg
// Brief  : Shared types and constants for the DMEM router: memory command,
//          width and response encodings, the router port identifier, the
//          default port-0 window and the address decode helper.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package scr1_dmem_router_pkg;

    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;

    // Default port-0 (TCM) window
    localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_DMEM_RTR_PORT0_BASE = 32'hF000_0000;
    localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_DMEM_RTR_PORT0_MASK = 32'hFFFF_0000;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic {
        SCR1_DMEM_RTR_PORT0 = 1'b0,
        SCR1_DMEM_RTR_PORT1 = 1'b1
    } type_scr1_dmem_rtr_port_e;

    // Port 0 owns the masked window; everything else goes to the fabric.
    function automatic type_scr1_dmem_rtr_port_e scr1_dmem_rtr_decode(
        input logic [SCR1_DMEM_AWIDTH-1:0] addr,
        input logic [SCR1_DMEM_AWIDTH-1:0] base,
        input logic [SCR1_DMEM_AWIDTH-1:0] mask
    );
        return ((addr & mask) == base) ? SCR1_DMEM_RTR_PORT0 : SCR1_DMEM_RTR_PORT1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scr1_dmem_rtr_fifo.sv
//==============================================================================
// Module : scr1_dmem_rtr_fifo
// Brief  : Port-ID FIFO recording, in issue order, which port owes the core
//          its next response.
// Ports  : clk, rst (async, active high)
//          i_push/i_push_id  enqueue a port ID (ignored when full)
//          i_pop             dequeue the head (ignored when empty)
//          o_head            port ID at the head
//          o_full/o_empty    occupancy flags
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module scr1_dmem_rtr_fifo
    import scr1_dmem_router_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  type_scr1_dmem_rtr_port_e i_push_id,
    input  logic                     i_pop,
    output type_scr1_dmem_rtr_port_e o_head,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int           PW         = $clog2(DEPTH);
    localparam logic [PW:0]  C_PTR_ONE  = {{PW{1'b0}}, 1'b1};

    // Pointers carry one bit beyond the index: equal index with differing
    // top bit means full, fully equal means empty.
    type_scr1_dmem_rtr_port_e r_mem [DEPTH];
    logic [PW:0]              r_wptr;
    logic [PW:0]              r_rptr;
    logic                     w_push;
    logic                     w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign o_head  = r_mem[r_rptr[PW-1:0]];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= SCR1_DMEM_RTR_PORT0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr[PW-1:0]] <= i_push_id;
                r_wptr                <= r_wptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + C_PTR_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/scr1_dmem_router.sv
//==============================================================================
// Module : scr1_dmem_router
// Brief  : Routes the core DMEM interface to port 0 (TCM window) or port 1
//          (external fabric). Requests pass through with zero latency; up to
//          OUTST_DEPTH may be outstanding and responses return in issue order.
// Ports  : clk, rst (async, active high)
//          core_*    request in / ack, rdata, resp out
//          port0_*   request out / ack, rdata, resp in (TCM)
//          port1_*   request out / ack, rdata, resp in (fabric)
// Config : SCR1_DMEM_RTR_TIMEOUT_EN - adds a head-response timer
//          (TIMEOUT_CYCLES) that answers RDY_ER on expiry and discards the
//          late response the timed-out port eventually returns.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module scr1_dmem_router
    import scr1_dmem_router_pkg::*;
#(
    parameter logic [SCR1_DMEM_AWIDTH-1:0] PORT0_BASE = SCR1_DMEM_RTR_PORT0_BASE,
    parameter logic [SCR1_DMEM_AWIDTH-1:0] PORT0_MASK = SCR1_DMEM_RTR_PORT0_MASK,
    parameter int                          OUTST_DEPTH = 2
`ifdef SCR1_DMEM_RTR_TIMEOUT_EN
    ,parameter int                         TIMEOUT_CYCLES = 255
`endif
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         core_req_i,
    input  type_scr1_mem_cmd_e           core_cmd_i,
    input  type_scr1_mem_width_e         core_width_i,
    input  logic [SCR1_DMEM_AWIDTH-1:0]  core_addr_i,
    input  logic [SCR1_DMEM_DWIDTH-1:0]  core_wdata_i,
    output logic                         core_req_ack_o,
    output logic [SCR1_DMEM_DWIDTH-1:0]  core_rdata_o,
    output type_scr1_mem_resp_e          core_resp_o,
    output logic                         port0_req_o,
    output type_scr1_mem_cmd_e           port0_cmd_o,
    output type_scr1_mem_width_e         port0_width_o,
    output logic [SCR1_DMEM_AWIDTH-1:0]  port0_addr_o,
    output logic [SCR1_DMEM_DWIDTH-1:0]  port0_wdata_o,
    input  logic                         port0_req_ack_i,
    input  logic [SCR1_DMEM_DWIDTH-1:0]  port0_rdata_i,
    input  type_scr1_mem_resp_e          port0_resp_i,
    output logic                         port1_req_o,
    output type_scr1_mem_cmd_e           port1_cmd_o,
    output type_scr1_mem_width_e         port1_width_o,
    output logic [SCR1_DMEM_AWIDTH-1:0]  port1_addr_o,
    output logic [SCR1_DMEM_DWIDTH-1:0]  port1_wdata_o,
    input  logic                         port1_req_ack_i,
    input  logic [SCR1_DMEM_DWIDTH-1:0]  port1_rdata_i,
    input  type_scr1_mem_resp_e          port1_resp_i
);

    type_scr1_dmem_rtr_port_e    w_sel;
    type_scr1_dmem_rtr_port_e    w_head;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_req_ok;
    logic                        w_sel_ack;
    logic                        w_pop;
    type_scr1_mem_resp_e         w_head_resp_raw;
    type_scr1_mem_resp_e         w_head_resp;
    logic [SCR1_DMEM_DWIDTH-1:0] w_head_rdata;

    //--------------------------------------------------------------------------
    // Request path
    //--------------------------------------------------------------------------
    assign w_sel = scr1_dmem_rtr_decode(core_addr_i, PORT0_BASE, PORT0_MASK);

    // Full blocks issue even when a pop lands in the same cycle, so there is
    // no combinational path from a port response to a request ack. Holding
    // off during reset keeps the ports quiet while the FIFO is cleared.
    assign w_req_ok       = core_req_i & ~w_full & ~rst;
    assign port0_req_o    = w_req_ok & (w_sel == SCR1_DMEM_RTR_PORT0);
    assign port1_req_o    = w_req_ok & (w_sel == SCR1_DMEM_RTR_PORT1);
    assign w_sel_ack      = (w_sel == SCR1_DMEM_RTR_PORT0) ? port0_req_ack_i : port1_req_ack_i;
    assign core_req_ack_o = w_sel_ack & ~w_full & ~rst;

    assign port0_cmd_o   = core_cmd_i;
    assign port0_width_o = core_width_i;
    assign port0_addr_o  = core_addr_i;
    assign port0_wdata_o = core_wdata_i;
    assign port1_cmd_o   = core_cmd_i;
    assign port1_width_o = core_width_i;
    assign port1_addr_o  = core_addr_i;
    assign port1_wdata_o = core_wdata_i;

    scr1_dmem_rtr_fifo #(
        .DEPTH     (OUTST_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (core_req_ack_o),
        .i_push_id (w_sel),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    //--------------------------------------------------------------------------
    // Response path: only the head port is listened to
    //--------------------------------------------------------------------------
    assign w_head_resp_raw = (w_head == SCR1_DMEM_RTR_PORT0) ? port0_resp_i  : port1_resp_i;
    assign w_head_rdata    = (w_head == SCR1_DMEM_RTR_PORT0) ? port0_rdata_i : port1_rdata_i;

`ifdef SCR1_DMEM_RTR_TIMEOUT_EN
    localparam int DCW = $clog2(OUTST_DEPTH) + 1;

    logic [7:0]     r_tmo_cnt;
    logic [DCW-1:0] r_drop_cnt [2];
    logic [1:0]     w_discard;
    logic [1:0]     w_drop_inc;
    logic           w_wait;
    logic           w_timeout;

    // A port that still owes a timed-out response has its next response
    // swallowed, whether or not that port is currently at the head.
    assign w_discard[0]  = (r_drop_cnt[0] != '0) & (port0_resp_i != SCR1_MEM_RESP_NOTRDY);
    assign w_discard[1]  = (r_drop_cnt[1] != '0) & (port1_resp_i != SCR1_MEM_RESP_NOTRDY);
    assign w_head_resp   = w_discard[w_head] ? SCR1_MEM_RESP_NOTRDY : w_head_resp_raw;

    // A real response in the expiry cycle wins because w_wait goes low.
    assign w_wait        = ~w_empty & (w_head_resp == SCR1_MEM_RESP_NOTRDY);
    assign w_timeout     = w_wait & (r_tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign w_pop         = (~w_empty & (w_head_resp != SCR1_MEM_RESP_NOTRDY)) | w_timeout;
    assign w_drop_inc[0] = w_timeout & (w_head == SCR1_DMEM_RTR_PORT0);
    assign w_drop_inc[1] = w_timeout & (w_head == SCR1_DMEM_RTR_PORT1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_pop) begin
            r_tmo_cnt <= '0;
        end else if (w_wait) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt[0] <= '0;
            r_drop_cnt[1] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_drop_inc[p] & ~w_discard[p]) begin
                    r_drop_cnt[p] <= r_drop_cnt[p] + DCW'(1);
                end else if (w_discard[p] & ~w_drop_inc[p]) begin
                    r_drop_cnt[p] <= r_drop_cnt[p] - DCW'(1);
                end
            end
        end
    end

    always_comb begin
        core_resp_o  = SCR1_MEM_RESP_NOTRDY;
        core_rdata_o = '0;
        if (!w_empty) begin
            core_resp_o  = w_timeout ? SCR1_MEM_RESP_RDY_ER : w_head_resp;
            core_rdata_o = w_head_rdata;
        end
    end
`else
    assign w_head_resp = w_head_resp_raw;
    assign w_pop       = ~w_empty & (w_head_resp != SCR1_MEM_RESP_NOTRDY);

    always_comb begin
        core_resp_o  = SCR1_MEM_RESP_NOTRDY;
        core_rdata_o = '0;
        if (!w_empty) begin
            core_resp_o  = w_head_resp;
            core_rdata_o = w_head_rdata;
        end
    end
`endif

endmodule

`default_nettype wire
